// File: rtl/gadget_pkg.sv
// Shared types and constants for the falling power-up gadget logic.
// Contents:
//   NUM_SLOTS, SPRITE_W, SCREEN_H, FALL_STEP  geometry and capacity
//   gadget_type_t                             gadget kinds (G_NONE means empty / no sprite)
//   gadget_slot_t                             one on-screen gadget {valid, gtype, x, y}
//   type_legal()                              spawn type filter (1..8)
//   lowest_onehot()                           lowest-index priority pick
package gadget_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SPRITE_W  = 32;
    localparam int SCREEN_H  = 480;
    localparam int FALL_STEP = 2;

    typedef enum logic [3:0] {
        G_NONE       = 4'd0,
        G_BIG        = 4'd1,
        G_SHRINK     = 4'd2,
        G_GRAB       = 4'd3,
        G_FASTER     = 4'd4,
        G_SLOWER     = 4'd5,
        G_FIRE       = 4'd6,
        G_BIG_BALL   = 4'd7,
        G_SMALL_BALL = 4'd8
    } gadget_type_t;

    typedef struct packed {
        logic         valid;
        gadget_type_t gtype;
        logic [9:0]   x;
        logic [9:0]   y;
    } gadget_slot_t;

    function automatic logic type_legal(input logic [3:0] t);
        return (t != 4'd0) && (t <= 4'd8);
    endfunction

    // Two's-complement trick: v & -v keeps only the lowest set bit.
    function automatic logic [NUM_SLOTS-1:0] lowest_onehot(input logic [NUM_SLOTS-1:0] v);
        return v & (~v + {{(NUM_SLOTS-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/gadget_slot.sv
// One gadget slot: holds {valid, type, x, y}, loads on spawn, falls on
// frame_tick, frees itself when it leaves the screen or when the top picks
// it as the reported catch.
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   load                    take spawn_type/spawn_x at y=0 (only asserted when free)
//   spawn_type, spawn_x     spawn payload
//   frame_tick              per-frame motion strobe
//   paddle_x/_w/_y          paddle rectangle for the catch test
//   catch_free              this slot is the catch being reported; free it
//   slot                    current slot contents
//   catch_hit               combinational: tick this cycle lands on the paddle
module gadget_slot
    import gadget_pkg::*;
(
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [3:0]   spawn_type,
    input  logic [9:0]   spawn_x,
    input  logic         frame_tick,
    input  logic [9:0]   paddle_x,
    input  logic [9:0]   paddle_w,
    input  logic [9:0]   paddle_y,
    input  logic         catch_free,
    output gadget_slot_t slot,
    output logic         catch_hit
);

    gadget_slot_t slot_r;
    logic [10:0]  y_next_s;
    logic         off_screen_s;
    logic [11:0]  pad_right_s;
    logic [11:0]  x_right_s;
    logic [11:0]  y_bot_s;
    logic         overlap_s;

    // Next position and paddle overlap, evaluated on the post-move row.
    always_comb begin
        y_next_s     = {1'b0, slot_r.y} + 11'(FALL_STEP);
        off_screen_s = (y_next_s >= 11'(SCREEN_H));
        pad_right_s  = {2'b00, paddle_x} + {2'b00, paddle_w};
        x_right_s    = {2'b00, slot_r.x} + 12'(SPRITE_W);
        y_bot_s      = {1'b0, y_next_s} + 12'(SPRITE_W);
        // y_next < paddle_y + 1 written as <= to avoid the extra adder
        overlap_s    = ({2'b00, slot_r.x} < pad_right_s) &&
                       (x_right_s > {2'b00, paddle_x}) &&
                       (y_bot_s > {2'b00, paddle_y}) &&
                       ({1'b0, y_next_s} <= {2'b00, paddle_y});
        catch_hit    = slot_r.valid && frame_tick && !off_screen_s && overlap_s;
    end

    // Slot state: motion/free on tick for live slots, load for free slots.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            slot_r.valid <= 1'b0;
            slot_r.gtype <= G_NONE;
            slot_r.x     <= 10'd0;
            slot_r.y     <= 10'd0;
        end else if (slot_r.valid && frame_tick) begin
            if (off_screen_s || catch_free) begin
                slot_r.valid <= 1'b0;
                slot_r.gtype <= G_NONE;
            end else begin
                slot_r.y <= y_next_s[9:0];
            end
        end else if (load) begin
            slot_r.valid <= 1'b1;
            slot_r.gtype <= gadget_type_t'(spawn_type);
            slot_r.x     <= spawn_x;
            slot_r.y     <= 10'd0;
        end else begin
            slot_r <= slot_r;
        end
    end

    assign slot = slot_r;

endmodule

// File: rtl/gadget_sprite_fetch.sv
// Falling power-up gadget manager and sprite fetch pipeline.
// Owns NUM_SLOTS gadget slots, accepts spawns, moves gadgets once per frame,
// reports paddle catches and drives the 32x32 gadget sprite ROM address/type.
// DrawX/DrawY -> gadget_on/gadget_idx has two cycles of latency.
// Ports:
//   Clk, Reset                  clock, synchronous active-high reset
//   frame_tick                  one pulse per frame
//   spawn_valid/_ready/_type/_x spawn handshake (illegal types accepted and dropped)
//   paddle_x, paddle_w, paddle_y paddle rectangle
//   caught_valid, caught_type   one-cycle catch report
//   DrawX, DrawY                current VGA pixel
//   rom_addr, rom_type          sprite ROM request (type 0 = no gadget)
//   rom_data                    sprite ROM texel (combinational)
//   gadget_on, gadget_idx       opaque gadget texel and its palette index
// Build option: define GADGET_BLINK_EN to blink gadgets near the bottom of
// the screen (hidden every other 4 frames once y >= SCREEN_H-96).
module gadget_sprite_fetch
    import gadget_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        spawn_valid,
    output logic        spawn_ready,
    input  logic [3:0]  spawn_type,
    input  logic [9:0]  spawn_x,
    input  logic [9:0]  paddle_x,
    input  logic [9:0]  paddle_w,
    input  logic [9:0]  paddle_y,
    output logic        caught_valid,
    output logic [3:0]  caught_type,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [18:0] rom_addr,
    output logic [3:0]  rom_type,
    input  logic [3:0]  rom_data,
    output logic        gadget_on,
    output logic [3:0]  gadget_idx
);

    gadget_slot_t         slots_s [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] valid_s;
    logic [NUM_SLOTS-1:0] load_s;
    logic [NUM_SLOTS-1:0] catch_s;
    logic [NUM_SLOTS-1:0] catch_sel_s;
    logic [3:0]           catch_type_s;
    logic [10:0]          dx_s [NUM_SLOTS];
    logic [10:0]          dy_s [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] hit_s;
    logic [NUM_SLOTS-1:0] hit_sel_s;
    logic [9:0]           addr_sel_s;
    logic [3:0]           type_sel_s;

    logic        caught_valid_r;
    logic [3:0]  caught_type_r;
    logic [18:0] rom_addr_r;
    logic [3:0]  rom_type_r;
    logic        hit_r;
    logic        gadget_on_r;
    logic [3:0]  gadget_idx_r;
`ifdef GADGET_BLINK_EN
    logic [2:0]  blink_cnt_r;
`endif

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        gadget_slot u_slot (
            .Clk        (Clk),
            .Reset      (Reset),
            .load       (load_s[g]),
            .spawn_type (spawn_type),
            .spawn_x    (spawn_x),
            .frame_tick (frame_tick),
            .paddle_x   (paddle_x),
            .paddle_w   (paddle_w),
            .paddle_y   (paddle_y),
            .catch_free (catch_sel_s[g]),
            .slot       (slots_s[g]),
            .catch_hit  (catch_s[g])
        );
    end

    // Spawn allocation and catch selection; both pick the lowest index.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            valid_s[i] = slots_s[i].valid;
        end
        spawn_ready = ~&valid_s;
        // An illegal type still completes the handshake but loads nothing.
        load_s = (spawn_valid && spawn_ready && type_legal(spawn_type)) ?
                 lowest_onehot(~valid_s) : {NUM_SLOTS{1'b0}};
        catch_sel_s  = lowest_onehot(catch_s);
        catch_type_s = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            catch_type_s = catch_type_s | (catch_sel_s[i] ? slots_s[i].gtype : 4'd0);
        end
    end

    // Per-slot sprite-local offsets; 11-bit difference, sign bit set = left/above.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            dx_s[i]  = {1'b0, DrawX} - {1'b0, slots_s[i].x};
            dy_s[i]  = {1'b0, DrawY} - {1'b0, slots_s[i].y};
            hit_s[i] = slots_s[i].valid &&
                       !dx_s[i][10] && (dx_s[i][9:5] == 5'd0) &&
                       !dy_s[i][10] && (dy_s[i][9:5] == 5'd0)
`ifdef GADGET_BLINK_EN
                       && !(blink_cnt_r[2] && (slots_s[i].y >= 10'(SCREEN_H - 96)))
`endif
                       ;
        end
        hit_sel_s  = lowest_onehot(hit_s);
        addr_sel_s = 10'd0;
        type_sel_s = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            // SPRITE_W is 32, so row*32+col is just {row, col}.
            addr_sel_s = addr_sel_s | (hit_sel_s[i] ? {dy_s[i][4:0], dx_s[i][4:0]} : 10'd0);
            type_sel_s = type_sel_s | (hit_sel_s[i] ? slots_s[i].gtype : 4'd0);
        end
    end

    // Catch reporter: one-cycle pulse the cycle after the tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            caught_valid_r <= 1'b0;
            caught_type_r  <= 4'd0;
        end else begin
            caught_valid_r <= |catch_sel_s;
            caught_type_r  <= catch_type_s;
        end
    end

    // Draw stage 1: register ROM request and hit flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_r <= 19'd0;
            rom_type_r <= 4'd0;
            hit_r      <= 1'b0;
        end else begin
            rom_addr_r <= {9'd0, addr_sel_s};
            rom_type_r <= type_sel_s;
            hit_r      <= |hit_sel_s;
        end
    end

    // Draw stage 2: texel index 0 is transparent.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            gadget_on_r  <= 1'b0;
            gadget_idx_r <= 4'd0;
        end else begin
            gadget_on_r  <= hit_r && (rom_data != 4'd0);
            gadget_idx_r <= hit_r ? rom_data : 4'd0;
        end
    end

`ifdef GADGET_BLINK_EN
    // Blink phase counter, one step per frame.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            blink_cnt_r <= 3'd0;
        end else if (frame_tick) begin
            blink_cnt_r <= blink_cnt_r + 3'd1;
        end else begin
            blink_cnt_r <= blink_cnt_r;
        end
    end
`endif

    assign caught_valid = caught_valid_r;
    assign caught_type  = caught_type_r;
    assign rom_addr     = rom_addr_r;
    assign rom_type     = rom_type_r;
    assign gadget_on    = gadget_on_r;
    assign gadget_idx   = gadget_idx_r;

endmodule

// File: tb/tb_gadget_sprite_fetch.sv
// Directed bench for gadget_sprite_fetch: draw-pipeline vector table plus
// hand-written sequences for slot filling, off-screen free, catches and reset.
module tb_gadget_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_tick;
    logic        spawn_valid;
    logic        spawn_ready;
    logic [3:0]  spawn_type;
    logic [9:0]  spawn_x;
    logic [9:0]  paddle_x;
    logic [9:0]  paddle_w;
    logic [9:0]  paddle_y;
    logic        caught_valid;
    logic [3:0]  caught_type;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [18:0] rom_addr;
    logic [3:0]  rom_type;
    logic [3:0]  rom_data;
    logic        gadget_on;
    logic [3:0]  gadget_idx;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    typedef struct {
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic [3:0]  rdata;
        logic [18:0] exp_addr;
        logic [3:0]  exp_type;
        logic        exp_on;
        logic [3:0]  exp_idx;
    } vec_t;

    vec_t vecs [10];

    gadget_sprite_fetch dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .spawn_valid  (spawn_valid),
        .spawn_ready  (spawn_ready),
        .spawn_type   (spawn_type),
        .spawn_x      (spawn_x),
        .paddle_x     (paddle_x),
        .paddle_w     (paddle_w),
        .paddle_y     (paddle_y),
        .caught_valid (caught_valid),
        .caught_type  (caught_type),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .rom_addr     (rom_addr),
        .rom_type     (rom_type),
        .rom_data     (rom_data),
        .gadget_on    (gadget_on),
        .gadget_idx   (gadget_idx)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (caught_valid === 1'b1) pulse_cnt = pulse_cnt + 1;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic spawn(input logic [3:0] t, input logic [9:0] x);
        spawn_type  = t;
        spawn_x     = x;
        spawn_valid = 1'b1;
        step();
        spawn_valid = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic draw(input string name, input logic [9:0] x, input logic [9:0] y,
                        input logic [3:0] rdata, input logic [18:0] eaddr,
                        input logic [3:0] etype, input logic eon, input logic [3:0] eidx);
        DrawX = x;
        DrawY = y;
        step();
        check({name, ".rom_addr"}, 32'(rom_addr), 32'(eaddr));
        check({name, ".rom_type"}, 32'(rom_type), 32'(etype));
        rom_data = rdata;
        step();
        check({name, ".gadget_on"}, 32'(gadget_on), 32'(eon));
        check({name, ".gadget_idx"}, 32'(gadget_idx), 32'(eidx));
        rom_data = 4'd0;
    endtask

    initial begin
        // slot0: type 4 at (100,6); slot1: type 7 at (110,0)
        vecs[0] = '{10'd110, 10'd10, 4'd5,  19'd138,  4'd4, 1'b1, 4'd5};
        vecs[1] = '{10'd99,  10'd10, 4'd7,  19'd0,    4'd0, 1'b0, 4'd0};
        vecs[2] = '{10'd131, 10'd37, 4'd15, 19'd1023, 4'd4, 1'b1, 4'd15};
        vecs[3] = '{10'd142, 10'd10, 4'd9,  19'd0,    4'd0, 1'b0, 4'd0};
        vecs[4] = '{10'd100, 10'd5,  4'd0,  19'd0,    4'd0, 1'b0, 4'd0};
        vecs[5] = '{10'd100, 10'd38, 4'd3,  19'd0,    4'd0, 1'b0, 4'd0};
        vecs[6] = '{10'd100, 10'd6,  4'd0,  19'd0,    4'd4, 1'b0, 4'd0};
        vecs[7] = '{10'd115, 10'd10, 4'd0,  19'd143,  4'd4, 1'b0, 4'd0};
        vecs[8] = '{10'd140, 10'd2,  4'd3,  19'd94,   4'd7, 1'b1, 4'd3};
        vecs[9] = '{10'd141, 10'd31, 4'd1,  19'd1023, 4'd7, 1'b1, 4'd1};

        Reset = 1'b1; frame_tick = 1'b0; spawn_valid = 1'b0; spawn_type = 4'd0;
        spawn_x = 10'd0; paddle_x = 10'd0; paddle_w = 10'd0; paddle_y = 10'd0;
        DrawX = 10'd0; DrawY = 10'd0; rom_data = 4'd0;
        step(); step();
        check("rst.spawn_ready", 32'(spawn_ready), 32'd1);
        check("rst.caught_valid", 32'(caught_valid), 32'd0);
        check("rst.caught_type", 32'(caught_type), 32'd0);
        check("rst.rom_addr", 32'(rom_addr), 32'd0);
        check("rst.rom_type", 32'(rom_type), 32'd0);
        check("rst.gadget_on", 32'(gadget_on), 32'd0);
        check("rst.gadget_idx", 32'(gadget_idx), 32'd0);
        Reset = 1'b0;
        step();

        // Draw pipeline table
        spawn(4'd4, 10'd100);
        repeat (3) tick();
        spawn(4'd7, 10'd110);
        for (int i = 0; i < 10; i++) begin
            draw($sformatf("vec%0d", i), vecs[i].dx, vecs[i].dy, vecs[i].rdata,
                 vecs[i].exp_addr, vecs[i].exp_type, vecs[i].exp_on, vecs[i].exp_idx);
        end

        // Illegal type consumes no slot; fill remaining slots
        spawn(4'd0, 10'd200);
        check("illegal.ready", 32'(spawn_ready), 32'd1);
        spawn(4'd1, 10'd400);
        check("third.ready", 32'(spawn_ready), 32'd1);
        spawn(4'd2, 10'd600);
        check("full.ready", 32'(spawn_ready), 32'd0);

        // Fifth spawn held while full; slot0 falls off the bottom
        spawn_type = 4'd8; spawn_x = 10'd300; spawn_valid = 1'b1;
        repeat (236) tick();
        check("held.ready", 32'(spawn_ready), 32'd0);
        draw("y478", 10'd100, 10'd478, 4'd2, 19'd0, 4'd4, 1'b1, 4'd2);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("offscreen.ready", 32'(spawn_ready), 32'd1);
        check("offscreen.no_catch", 32'(caught_valid), 32'd0);
        step();
        spawn_valid = 1'b0;
        check("refill.ready", 32'(spawn_ready), 32'd0);
        draw("freed", 10'd100, 10'd478, 4'd2, 19'd0, 4'd0, 1'b0, 4'd0);
        check("no_pulses", 32'(pulse_cnt), 32'd0);
        draw("refilled", 10'd300, 10'd0, 4'd6, 19'd0, 4'd8, 1'b1, 4'd6);

        // Reset with live gadgets and a lit pixel in flight
        Reset = 1'b1;
        step();
        check("rst2.spawn_ready", 32'(spawn_ready), 32'd1);
        check("rst2.rom_addr", 32'(rom_addr), 32'd0);
        check("rst2.rom_type", 32'(rom_type), 32'd0);
        check("rst2.gadget_on", 32'(gadget_on), 32'd0);
        check("rst2.gadget_idx", 32'(gadget_idx), 32'd0);
        check("rst2.caught_valid", 32'(caught_valid), 32'd0);
        Reset = 1'b0;
        step();
        draw("rst2.cleared", 10'd300, 10'd0, 4'd6, 19'd0, 4'd0, 1'b0, 4'd0);

        // Spawn in the same cycle as a tick enters at y=0
        spawn_type = 4'd2; spawn_x = 10'd500; spawn_valid = 1'b1; frame_tick = 1'b1;
        step();
        spawn_valid = 1'b0; frame_tick = 1'b0;
        draw("spawn_tick", 10'd500, 10'd0, 4'd4, 19'd0, 4'd2, 1'b1, 4'd4);

        // Two gadgets caught on the same tick: lower index first, other next tick
        paddle_x = 10'd90; paddle_w = 10'd64; paddle_y = 10'd440;
        spawn(4'd5, 10'd100);
        spawn(4'd6, 10'd120);
        pulse_cnt = 0;
        repeat (204) tick();
        check("precatch.pulses", 32'(pulse_cnt), 32'd0);
        draw("y408", 10'd100, 10'd408, 4'd1, 19'd0, 4'd5, 1'b1, 4'd1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("catch1.valid", 32'(caught_valid), 32'd1);
        check("catch1.type", 32'(caught_type), 32'd5);
        step();
        check("catch1.pulse_end", 32'(caught_valid), 32'd0);
        draw("catch1.freed", 10'd100, 10'd410, 4'd1, 19'd0, 4'd0, 1'b0, 4'd0);
        draw("catch2.kept", 10'd120, 10'd410, 4'd1, 19'd0, 4'd6, 1'b1, 4'd1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("catch2.valid", 32'(caught_valid), 32'd1);
        check("catch2.type", 32'(caught_type), 32'd6);
        step();
        repeat (10) tick();
        check("catch.once", 32'(pulse_cnt), 32'd2);
        check("catch.ready", 32'(spawn_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
